tick_sched: RTL
===============

Name: tick_sched

Overview:
- Clock-enable scheduler driven by the on-chip oscillator clock (OSC, FREQ_DIV=10).
- Generates NUM_CH independent single-cycle tick enables with runtime-programmable periods, for LED blink, LCD refresh and similar consumers.
- Configuration changes to a running channel are deferred to that channel's period boundary, so no tick is ever shortened or doubled.
- Sits between the oscillator wrapper and the application logic; all consumers stay on sys_clk and qualify their logic with tick.

Parameters:
- NUM_CH, 4, number of tick channels (1..8).
- DIV_W, 24, width of the per-channel period register.

Ports:
- sys_clk  in  1  oscillator-derived clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  scheduler can accept a configuration.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  period in sys_clk cycles; 0 is treated as 1.
- cfg_en  in  1  channel enable value to apply.
- cfg_err  out  1  one-cycle pulse: request rejected (cfg_ch >= NUM_CH).
- sync_start  in  1  realign all enabled channels.
- tick  out  NUM_CH  per-channel one-cycle enable.

Behaviour:
- Reset (async assert, sync release): all channels disabled, divisors=1, counters=0, tick=0, cfg_err=0, FSM=IDLE, cfg_ready=1.
- Reset mid-operation discards any pending update.
- Per channel: counter counts 0..D-1 while enabled (D = max(div,1)).
  - Edge with counter==D-1: counter<=0, tick[i]<=1; otherwise tick[i]<=0.
  - Disabled channel: counter held at 0, tick[i]=0.
  - After the edge where an enable takes effect (call it E), tick[i] is high in the cycle after edge E+D, then every D cycles.
  - D=1 gives tick[i] continuously high.
- Handshake: a request is accepted on the edge with cfg_valid & cfg_ready.
  - cfg_ready = (FSM==IDLE), combinational from the state register.
- Config FSM:
  - IDLE, request with cfg_ch >= NUM_CH: cfg_err pulses the next cycle; FSM stays IDLE.
  - IDLE, target channel currently disabled: update (div, en) applied on the next edge with counter=0; FSM stays IDLE.
  - IDLE, target channel enabled: request latched, FSM -> PEND.
  - PEND: update applied on the target channel's wrap edge; the tick still fires on that edge; counter restarts at 0 with the new D; FSM -> IDLE.
  - PEND with cfg_en=0: the channel emits its final tick on the wrap edge, then is disabled.
- sync_start edge: every enabled channel counter<=0, tick<=0.
  - A pending update is applied on the same edge (sync counts as a boundary); FSM -> IDLE.
  - sync_start and wrap on the same edge: sync wins; no tick on that edge.
- cfg_div width: the full DIV_W is used; no overflow, since the counter is DIV_W wide and compares against D-1.

Optional Feature:
- Macro: TICK_SCHED_CNT_EN.
- Defined: adds input rd_ch (3 bits) and output rd_cnt (16 bits).
  - rd_cnt is a registered (1-cycle latency) free-running, wrapping count of ticks issued on channel rd_ch.
  - The count clears on reset and on that channel's enable transition 0->1.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package tick_sched_pkg:
  - NUM_CH and DIV_W defaults.
  - Config FSM enum {IDLE, PEND}.
  - Channel-index width constant.
- Sub-module tick_sched_chan: one channel (period register, enable, counter, tick, wrap strobe, apply input), instantiated NUM_CH times.
- The top level holds the config FSM, the pending latch and the optional count mux.

Test Plan:
- Reset, then write ch0 div=5 en=1 with no other traffic -> tick[0] high for 1 cycle every 5 cycles; cfg_ready never drops.
- ch1 running div=4; write div=10 mid-period -> cfg_ready low until ch1 wraps; period 4 completes, then ticks at 10-cycle spacing; no short period.
- Write ch2 div=0 en=1 -> tick[2] constant 1; write ch2 en=0 -> after the boundary, tick[2]=0 and stays 0.
- Write cfg_ch=6 with NUM_CH=4 -> cfg_err pulses 1 cycle; no channel changes; cfg_ready stays 1.
- ch0 div=3, ch1 div=7 running; pulse sync_start on ch0's wrap edge -> no tick that cycle; ch0 ticks 3 and ch1 ticks 7 cycles after the sync edge.
- Assert sys_rst_n=0 while PEND -> tick=0 immediately; after release all channels disabled, cfg_ready=1; the pending update is never applied.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick enable scheduler.
package tick_sched_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DIV_W_DEF  = 24;
    localparam int CH_W       = 3;
    localparam int CNT_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/tick_sched_chan.sv
// One tick channel: period register, enable, phase counter; tick is registered (1 cycle after wrap).
// No backpressure; updates arrive through apply, which overrides the counter and config on that edge.
module tick_sched_chan
    import tick_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             apply,
    input  logic [DIV_W-1:0] upd_div,
    input  logic             upd_en,
    output logic             en,
    output logic             wrap,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // A period register of 0 behaves exactly like 1.
    assign last = (div == '0) ? '0 : div - DIV_W'(1);
    assign wrap = en && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= 1'b0;
            div  <= DIV_W'(1);
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap && !sync;
            if (en && !sync && !wrap) begin
                cnt <= cnt + DIV_W'(1);
            end else begin
                cnt <= '0;
            end
            if (apply) begin
                div <= upd_div;
                en  <= upd_en;
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tick_sched.sv
// NUM_CH programmable tick enables; ticks 1 cycle after wrap, cfg updates deferred to the channel boundary.
// cfg_ready drops while an update waits for its boundary. Optional per-channel tick counters: TICK_SCHED_CNT_EN.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    input  logic              sync_start,
`ifdef TICK_SCHED_CNT_EN
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_cnt,
`endif
    output logic [NUM_CH-1:0] tick
);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [DIV_W-1:0] div;
        logic             en;
    } cfg_req_t;

    cfg_state_t        state, state_nxt;
    cfg_req_t          pend, pend_nxt;
    logic              err_nxt;
    logic [DIV_W-1:0]  upd_div;
    logic              upd_en;
    logic [NUM_CH-1:0] sel, pend_sel, chan_en, wrap, apply;
    logic              acc, ch_ok, tgt_en, boundary;

    assign cfg_ready = (state == IDLE);
    assign acc       = cfg_valid && cfg_ready;
    assign ch_ok     = int'(cfg_ch) < NUM_CH;
    assign tgt_en    = |(sel & chan_en);
    // Sync realigns every channel, so it releases a pending update too.
    assign boundary  = sync_start || |(pend_sel & wrap);
    assign upd_div   = (state == PEND) ? pend.div : cfg_div;
    assign upd_en    = (state == PEND) ? pend.en  : cfg_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i]      = (cfg_ch == CH_W'(i));
        assign pend_sel[i] = (pend.ch == CH_W'(i));
        assign apply[i]    = (state == IDLE) ? (acc && sel[i] && !chan_en[i])
                                             : (pend_sel[i] && (sync_start || wrap[i]));

        tick_sched_chan #(.DIV_W(DIV_W)) u_chan (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .sync    (sync_start),
            .apply   (apply[i]),
            .upd_div (upd_div),
            .upd_en  (upd_en),
            .en      (chan_en[i]),
            .wrap    (wrap[i]),
            .tick    (tick[i])
        );
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (!ch_ok) begin
                        err_nxt = 1'b1;
                    end else if (tgt_en) begin
                        pend_nxt  = '{ch: cfg_ch, div: cfg_div, en: cfg_en};
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            cfg_err <= err_nxt;
        end
    end

`ifdef TICK_SCHED_CNT_EN
    logic [CNT_W-1:0] tick_cnt [NUM_CH];
    logic [CNT_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_mux = tick_cnt[i];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) tick_cnt[i] <= '0;
            rd_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply[i] && upd_en && !chan_en[i]) begin
                    tick_cnt[i] <= '0;
                end else if (tick[i]) begin
                    tick_cnt[i] <= tick_cnt[i] + CNT_W'(1);
                end
            end
            rd_cnt <= rd_mux;
        end
    end
`endif

endmodule
